// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux channel between four requesters.
// A grant is held for a whole burst; {s1,s0} drives the downstream mux tree.
module mux4_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [3:0]       last,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [3:0]       ack,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             s0,
    output logic             s1,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e           state_q;
    logic [1:0]       sel_q;
    logic [1:0]       ptr_q;

    logic [1:0]       pick;
    logic [WIDTH-1:0] mux_data;
    logic             granted;
    logic             cur_req;
    logic             cur_last;
    logic             beat_acc;
    logic             release_grant;

    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] win;
        win = p;
        // Scan from the farthest offset inward so the requester nearest ptr wins.
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) win = idx;
        end
        return win;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        mux_data = i0;
        case (sel_q)
            2'd1:    mux_data = i1;
            2'd2:    mux_data = i2;
            2'd3:    mux_data = i3;
            default: mux_data = i0;
        endcase

        pick      = rr_pick(req, ptr_q);
        granted   = (state_q == GRANT);
        cur_req   = req[sel_q];
        cur_last  = last[sel_q];

        out_valid = granted & cur_req;
        out_last  = out_valid & cur_last;
        out       = granted ? mux_data : '0;
        beat_acc  = out_valid & out_ready;

        ack        = '0;
        ack[sel_q] = beat_acc;

        // Ownership ends on an accepted last beat or when the owner drops its request.
        release_grant = granted & (~cur_req | (beat_acc & cur_last));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req != '0) begin
                        sel_q   <= pick;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_grant) begin
                        state_q <= IDLE;
                        ptr_q   <= sel_q + 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s0   = sel_q[0];
    assign s1   = sel_q[1];
    assign busy = granted;

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 mux output channel between four requesters.
- Each requester presents data plus request/last flags. The block registers a grant, drives the mux select pair (s1,s0), and forwards the granted requester's beats over a valid/ready output handshake.
- Sits in front of the gate-level 4:1 mux tree. Burst ownership is held until the granted requester's last beat is accepted.

Parameters:
- WIDTH, 8, data width of each input and of the output.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request per requester; bit k belongs to requester k.
- last  input  4  bit k high marks requester k's current beat as the final beat of its burst.
- i0  input  WIDTH  data from requester 0.
- i1  input  WIDTH  data from requester 1.
- i2  input  WIDTH  data from requester 2.
- i3  input  WIDTH  data from requester 3.
- ack  output  4  one-hot; bit k high when a beat from requester k is accepted this cycle.
- out  output  WIDTH  data of the granted requester.
- out_valid  output  1  out/out_last hold a valid beat.
- out_last  output  1  last[sel] of the granted requester.
- out_ready  input  1  downstream accepts the beat this cycle.
- s0  output  1  select bit 0, registered.
- s1  output  1  select bit 1, registered; sel = {s1,s0}.
- busy  output  1  high in state GRANT.

Behaviour:
- Reset (async, rst=1): state IDLE, sel=0, ptr=0, busy=0, out_valid=0, out_last=0, ack=0, out=0.
- States: IDLE and GRANT.
- IDLE:
  - If req!=0, select the first k with req[k]=1, scanning ptr, ptr+1, ... mod 4.
  - Load sel<=k and go to GRANT.
  - If req=0, stay in IDLE; sel holds its value.
- GRANT:
  - out=i[sel] (combinational from registered sel); out_valid=req[sel]; out_last=last[sel] & out_valid.
  - ack[sel]=out_valid & out_ready; all other ack bits are 0.
- GRANT exits:
  - Beat accepted with last[sel]=1: go to IDLE, ptr<=sel+1 mod 4 (wraps 3->0).
  - Beat accepted with last[sel]=0: stay in GRANT (burst continues).
  - req[sel]=0 (requester abandons): go to IDLE next cycle, ptr<=sel+1 mod 4, no ack.
  - out_valid=1 and out_ready=0: hold; out/out_last must stay stable as long as inputs are stable.
- Outputs in IDLE: out=0, out_valid=0, out_last=0, ack=0, busy=0.
- Latency: req rising in IDLE at edge n gives sel and out_valid valid after edge n+1. Minimum single-beat transaction is 2 cycles; no back-to-back grants without an IDLE cycle.
- Fairness: after serving k, requester k is the lowest priority. Every continuously requesting requester is granted within 3 bursts.
- Requests from non-granted requesters arriving during GRANT are ignored until IDLE; there is no preemption.
- Changing req/last of non-granted requesters has no effect on the outputs.
- ptr is internal, 2 bits, and wraps mod 4.
- Reset asserted mid-burst: immediate return to IDLE, outputs 0, ptr=0. A partial burst is not resumed.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles -> busy=0, out_valid=0, s1s0=00, ack=0.
- req=4'b0100, i2=8'hA5, last=4'b0100, out_ready=1 -> next cycle s1s0=10, out=8'hA5, out_valid=1, out_last=1, ack=4'b0100; following cycle IDLE, ptr=3.
- req=4'b1111 held, all last=1, out_ready=1 from reset -> grant order 0,1,2,3,0; each grant 1 beat followed by 1 IDLE cycle; ack pulses one-hot in that order.
- Burst from requester 1, last low for 3 beats then high, out_ready toggling 1,0,1,1,0,1 -> out stable while out_ready=0; exactly 4 acks; req[3] asserted mid-burst is granted only after last accepted.
- Granted requester 3 drops req before last -> out_valid=0, return to IDLE, next grant scans from 0 (wrap).
- rst pulsed while GRANT with out_valid=1 -> same cycle out_valid=0, busy=0, s1s0=00; after release, req=4'b0010 grants requester 1.
